// File: rtl/frame_seq_ctrl_pkg.sv
// Shared definitions for the frame capture/playback sequencer and its frame buffer datapath.
package frame_ctrl_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE    = 3'd0,
      ST_SETTLE  = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_SEND    = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   localparam int DEF_ROM_LENGTH = 2048;
   localparam int DEF_ADDR_DEPTH = 11;
   localparam int DEF_START_TIME = 24;
   localparam int DEF_SEND_SPEED = 14;

endpackage

// File: rtl/frame_seq_ctrl_if.sv
// Control, frame RAM and consumer handshake signals of the frame sequencer.
interface frame_seq_if #(
   parameter int ADDR_DEPTH = frame_ctrl_pkg::DEF_ADDR_DEPTH
);
   logic                              arm;
   logic                              abort;
   logic                              auto_rearm;
   logic                              tx_ack;
   logic                              wr_en;
   logic [ADDR_DEPTH-1:0]             wr_addr;
   logic                              rd_en;
   logic [ADDR_DEPTH-1:0]             rd_addr;
   logic                              tx_ok_out;
   logic                              busy;
   logic                              frame_done;
   logic                              overrun;
   logic [frame_ctrl_pkg::STATE_W-1:0] state_out;

   modport master (
      output arm, abort, auto_rearm, tx_ack,
      input  wr_en, wr_addr, rd_en, rd_addr, tx_ok_out, busy, frame_done, overrun, state_out
   );

   modport slave (
      input  arm, abort, auto_rearm, tx_ack,
      output wr_en, wr_addr, rd_en, rd_addr, tx_ok_out, busy, frame_done, overrun, state_out
   );
endinterface

// File: rtl/frame_seq_ctrl_tick_divider.sv
// Free-running power-of-two divider: tick is high in the last cycle of each 2^SEND_SPEED period.
module tick_divider
   import frame_ctrl_pkg::*;
#(
   parameter int SEND_SPEED = DEF_SEND_SPEED
) (
   input  logic adc_clk_out,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   logic [SEND_SPEED-1:0] r_cnt;

   assign tick = enable && (r_cnt == '1);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge adc_clk_out) begin
      if (clear) begin
         r_cnt <= '0;
      end else if (enable) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/frame_seq_ctrl.sv
// Frame sequencer: settle delay, one capture pass into the frame RAM, then paced playback with valid/ack.
module frame_seq_ctrl
   import frame_ctrl_pkg::*;
#(
   parameter int ROM_LENGTH = DEF_ROM_LENGTH,
   parameter int ADDR_DEPTH = DEF_ADDR_DEPTH,
   parameter int START_TIME = DEF_START_TIME,
   parameter int SEND_SPEED = DEF_SEND_SPEED
) (
   input  logic     adc_clk_out,
   input  logic     reset,
   frame_seq_if.slave bus
);

   localparam logic [ADDR_DEPTH-1:0] LAST_ADDR = ADDR_DEPTH'(ROM_LENGTH - 1);
   localparam logic [ADDR_DEPTH:0]   LAST_IDX  = (ADDR_DEPTH + 1)'(ROM_LENGTH - 1);

   state_t                r_state;
   logic [ADDR_DEPTH:0]   r_index;
   logic [ADDR_DEPTH-1:0] r_wr_addr;
   logic [ADDR_DEPTH-1:0] r_rd_addr;
   logic                  r_wr_en;
   logic                  r_rd_en;
   logic                  r_tx_ok;
   logic                  r_done;
   logic                  r_overrun;

   logic                  w_settle_clr;
   logic                  w_settle_tick;
   logic                  w_send_clr;
   logic                  w_send_tick;
   logic                  w_accept;
   logic [ADDR_DEPTH:0]   w_idx_next;

   assign w_settle_clr = reset || (r_state != ST_SETTLE);
   assign w_send_clr   = reset || (r_state != ST_SEND);
   assign w_accept     = r_tx_ok && bus.tx_ack;
   assign w_idx_next   = r_index + 1'b1;

   tick_divider #(.SEND_SPEED(START_TIME)) u_settle (
      .adc_clk_out (adc_clk_out),
      .clear       (w_settle_clr),
      .enable      (r_state == ST_SETTLE),
      .tick        (w_settle_tick)
   );

   tick_divider #(.SEND_SPEED(SEND_SPEED)) u_send (
      .adc_clk_out (adc_clk_out),
      .clear       (w_send_clr),
      .enable      (r_state == ST_SEND),
      .tick        (w_send_tick)
   );

   always_ff @(posedge adc_clk_out) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_index   <= '0;
         r_wr_addr <= '0;
         r_rd_addr <= '0;
         r_wr_en   <= 1'b0;
         r_rd_en   <= 1'b0;
         r_tx_ok   <= 1'b0;
         r_done    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_done  <= 1'b0;
         r_rd_en <= 1'b0;
         if (bus.abort) begin
            // Abort drops everything in flight but keeps the overrun history.
            r_state   <= ST_IDLE;
            r_index   <= '0;
            r_wr_addr <= '0;
            r_rd_addr <= '0;
            r_wr_en   <= 1'b0;
            r_tx_ok   <= 1'b0;
         end else begin
            unique case (r_state)
               ST_IDLE: begin
                  if (bus.arm) begin
                     r_state   <= ST_SETTLE;
                     r_overrun <= 1'b0;
                  end
               end
               ST_SETTLE: begin
                  if (w_settle_tick) begin
                     r_state   <= ST_CAPTURE;
                     r_wr_en   <= 1'b1;
                     r_wr_addr <= '0;
                  end
               end
               ST_CAPTURE: begin
                  if (r_wr_addr == LAST_ADDR) begin
                     r_state   <= ST_SEND;
                     r_wr_en   <= 1'b0;
                     r_wr_addr <= '0;
                     r_index   <= '0;
                  end else begin
                     r_wr_addr <= r_wr_addr + 1'b1;
                  end
               end
               ST_SEND: begin
                  // RAM data appears one cycle after rd_en, so valid follows the read.
                  if (r_rd_en) begin
                     r_tx_ok <= 1'b1;
                  end
                  if (w_accept) begin
                     r_tx_ok <= 1'b0;
                     r_index <= w_idx_next;
                  end
                  if (w_accept && (r_index == LAST_IDX)) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                     r_index <= '0;
                  end else if (w_send_tick) begin
                     if (r_tx_ok && !bus.tx_ack) begin
                        r_overrun <= 1'b1;
                     end else if (!r_rd_en) begin
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= w_accept ? w_idx_next[ADDR_DEPTH-1:0]
                                              : r_index[ADDR_DEPTH-1:0];
                     end
                  end
               end
               ST_DONE: begin
                  if (bus.auto_rearm) begin
                     r_state   <= ST_CAPTURE;
                     r_wr_en   <= 1'b1;
                     r_wr_addr <= '0;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign bus.wr_en      = r_wr_en;
   assign bus.wr_addr    = r_wr_addr;
   assign bus.rd_en      = r_rd_en;
   assign bus.rd_addr    = r_rd_addr;
   assign bus.tx_ok_out  = r_tx_ok;
   assign bus.busy       = (r_state != ST_IDLE);
   assign bus.frame_done = r_done;
   assign bus.overrun    = r_overrun;
   assign bus.state_out  = r_state;

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Scoreboard bench for frame_seq_ctrl with a small frame: expectations queued at stimulus, popped by a monitor.
module tb_frame_seq_ctrl;
   import frame_ctrl_pkg::*;

   localparam int ROM_LENGTH = 16;
   localparam int ADDR_DEPTH = 4;
   localparam int START_TIME = 3;
   localparam int SEND_SPEED = 2;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   frame_seq_if #(.ADDR_DEPTH(ADDR_DEPTH)) bus ();

   frame_seq_ctrl #(
      .ROM_LENGTH (ROM_LENGTH),
      .ADDR_DEPTH (ADDR_DEPTH),
      .START_TIME (START_TIME),
      .SEND_SPEED (SEND_SPEED)
   ) dut (
      .adc_clk_out (clk),
      .reset       (reset),
      .bus         (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   int wr_q[$];
   int rd_q[$];
   int dlv_q[$];
   int done_q[$];

   int   cur_sample  = -1;
   int   hold_sample = -1;
   int   hold_left   = 0;
   logic prev_rd_en  = 1'b0;

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual == expected) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
   endtask

   // Consumer and monitor share one process so the ack decision is visible to the checks.
   always @(negedge clk) begin
      if (reset) begin
         bus.tx_ack = 1'b0;
         prev_rd_en = 1'b0;
      end else begin
         if (bus.tx_ok_out && cur_sample == hold_sample && hold_left > 0) begin
            bus.tx_ack = 1'b0;
            hold_left--;
         end else begin
            bus.tx_ack = bus.tx_ok_out;
         end
         if (prev_rd_en) check("tx_ok_after_rd", int'(bus.tx_ok_out), 1);
         if (bus.wr_en) begin
            check("wr_expected", int'(wr_q.size() > 0), 1);
            if (wr_q.size() > 0) check("wr_addr", int'(bus.wr_addr), wr_q.pop_front());
         end
         if (bus.rd_en) begin
            check("rd_while_valid", int'(bus.tx_ok_out), 0);
            check("rd_expected", int'(rd_q.size() > 0), 1);
            if (rd_q.size() > 0) check("rd_addr", int'(bus.rd_addr), rd_q.pop_front());
            cur_sample = int'(bus.rd_addr);
         end
         if (bus.tx_ok_out && bus.tx_ack) begin
            check("dlv_expected", int'(dlv_q.size() > 0), 1);
            if (dlv_q.size() > 0) check("delivered_sample", cur_sample, dlv_q.pop_front());
         end
         if (bus.frame_done) begin
            check("done_state", int'(bus.state_out), 4);
            check("done_expected", int'(done_q.size() > 0), 1);
            if (done_q.size() > 0) check("done_overrun", int'(bus.overrun), done_q.pop_front());
         end
         prev_rd_en = bus.rd_en;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_frame(input int overrun_exp);
      for (int i = 0; i < ROM_LENGTH; i++) begin
         wr_q.push_back(i);
         rd_q.push_back(i);
         dlv_q.push_back(i);
      end
      done_q.push_back(overrun_exp);
   endtask

   task automatic pulse_arm();
      bus.arm = 1'b1;
      @(negedge clk);
      bus.arm = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name);
      int k = 0;
      while (!bus.frame_done && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(name, int'(bus.frame_done), 1);
   endtask

   task automatic wait_state(input int st, input int budget, input string name);
      int k = 0;
      while (int'(bus.state_out) != st && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(name, int'(bus.state_out), st);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_state"},   int'(bus.state_out),  0);
      check({tag, "_busy"},    int'(bus.busy),       0);
      check({tag, "_wr_en"},   int'(bus.wr_en),      0);
      check({tag, "_wr_addr"}, int'(bus.wr_addr),    0);
      check({tag, "_rd_en"},   int'(bus.rd_en),      0);
      check({tag, "_rd_addr"}, int'(bus.rd_addr),    0);
      check({tag, "_tx_ok"},   int'(bus.tx_ok_out),  0);
      check({tag, "_done"},    int'(bus.frame_done), 0);
      check({tag, "_overrun"}, int'(bus.overrun),    0);
   endtask

   initial begin
      bus.arm        = 1'b0;
      bus.abort      = 1'b0;
      bus.auto_rearm = 1'b0;

      // Power-on reset.
      cyc(3);
      check_all_zero("por");
      reset = 1'b0;
      cyc(2);

      // Nominal frame: settle timeline, capture, paced playback with immediate ack.
      push_frame(0);
      pulse_arm();
      check("a_busy_c1", int'(bus.busy), 1);
      for (int c = 1; c <= 25; c++) begin
         check($sformatf("a_state_c%0d", c), int'(bus.state_out), (c <= 8) ? 1 : (c <= 24) ? 2 : 3);
         if (c < 25) @(negedge clk);
      end
      wait_done(200, "a_frame_done");
      @(negedge clk);
      check("a_idle_after", int'(bus.state_out), 0);
      check("a_overrun", int'(bus.overrun), 0);

      // Sample 3 held for 10 cycles: ticks overrun, the coinciding ack lets the read of 4 proceed.
      hold_sample = 3;
      hold_left   = 10;
      push_frame(1);
      pulse_arm();
      wait_done(400, "b_frame_done");
      @(negedge clk);
      check("b_idle_after", int'(bus.state_out), 0);
      check("b_overrun_sticky", int'(bus.overrun), 1);
      check("b_hold_used", hold_left, 0);

      // Re-arm clears overrun; abort mid-capture.
      for (int i = 0; i < 8; i++) wr_q.push_back(i);
      pulse_arm();
      check("c_overrun_cleared", int'(bus.overrun), 0);
      begin
         int k = 0;
         while (!(bus.wr_en && int'(bus.wr_addr) == 7) && k < 50) begin
            @(negedge clk);
            k++;
         end
         check("c_reach_wr7", int'(bus.wr_addr), 7);
      end
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check("c_abort_state", int'(bus.state_out), 0);
      check("c_abort_wr_en", int'(bus.wr_en), 0);
      check("c_abort_wr_addr", int'(bus.wr_addr), 0);

      // arm and abort together in IDLE: abort wins.
      bus.arm   = 1'b1;
      bus.abort = 1'b1;
      @(negedge clk);
      bus.arm   = 1'b0;
      bus.abort = 1'b0;
      check("c_arm_abort_idle", int'(bus.state_out), 0);

      // Re-arm, capture restarts at 0; stall sample 0 into overrun, then abort keeps overrun.
      for (int i = 0; i < ROM_LENGTH; i++) wr_q.push_back(i);
      rd_q.push_back(0);
      hold_sample = 0;
      hold_left   = 1000;
      pulse_arm();
      begin
         int k = 0;
         while (!bus.overrun && k < 100) begin
            @(negedge clk);
            k++;
         end
         check("c_overrun_set", int'(bus.overrun), 1);
      end
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check("c_send_abort_state", int'(bus.state_out), 0);
      check("c_send_abort_tx_ok", int'(bus.tx_ok_out), 0);
      check("c_send_abort_rd_en", int'(bus.rd_en), 0);
      check("c_send_abort_overrun", int'(bus.overrun), 1);
      hold_left = 0;
      cyc(2);

      // auto_rearm: arm during SEND ignored, DONE goes straight to CAPTURE.
      bus.auto_rearm = 1'b1;
      push_frame(0);
      push_frame(0);
      pulse_arm();
      wait_state(3, 50, "d_reach_send");
      cyc(5);
      pulse_arm();
      check("d_arm_ignored", int'(bus.state_out), 3);
      wait_done(200, "d_frame1_done");
      @(negedge clk);
      check("d_rearm_state", int'(bus.state_out), 2);
      check("d_rearm_wr_en", int'(bus.wr_en), 1);
      check("d_rearm_wr_addr", int'(bus.wr_addr), 0);
      bus.auto_rearm = 1'b0;
      wait_done(200, "d_frame2_done");
      @(negedge clk);
      check("d_idle_after", int'(bus.state_out), 0);

      // Reset held 3 cycles while a sample is pending in SEND.
      for (int i = 0; i < ROM_LENGTH; i++) wr_q.push_back(i);
      rd_q.push_back(0);
      hold_sample = 0;
      hold_left   = 1000;
      pulse_arm();
      begin
         int k = 0;
         while (!bus.tx_ok_out && k < 60) begin
            @(negedge clk);
            k++;
         end
         check("e_pending", int'(bus.tx_ok_out), 1);
      end
      reset = 1'b1;
      @(negedge clk);
      check_all_zero("e_rst1");
      cyc(2);
      reset     = 1'b0;
      hold_left = 0;
      check_all_zero("e_rst3");
      cyc(3);
      check("e_stay_idle", int'(bus.state_out), 0);

      check("wr_q_drained",   wr_q.size(),   0);
      check("rd_q_drained",   rd_q.size(),   0);
      check("dlv_q_drained",  dlv_q.size(),  0);
      check("done_q_drained", done_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
